// File: rtl/fifo_sync_flags_pkg.sv
// Purpose: shared defaults and types for the synchronous flagged FIFO family.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_sync_flags_pkg;

  // Default geometry shared with other single-clock buffer blocks.
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH_P2 = 5;

  // Fill counter must hold 0..DEPTH inclusive, hence one bit more than a pointer.
  function automatic int fill_w(input int depth_p2);
    return $clog2(2 ** depth_p2) + 1;
  endfunction

  // Registered status flags, kept together so they update as one unit.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_sync_ram.sv
// Purpose: FIFO storage array, one synchronous write port, one async read port.
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none; the caller only writes when the FIFO accepts a word.
//
// Ports:
//   clk_i      rising-edge clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_dat_i   write data
//   rd_addr_i  read address (combinational read)
//   rd_dat_o   read data
module fifo_sync_ram
  import fifo_sync_flags_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_DEPTH_P2
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_dat_o
);

  // Storage deliberately has no reset; validity is tracked by the fill count.
  logic [WIDTH-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_sync_flags.sv
// Purpose: single-clock FIFO with almost flags, FWFT option, flush, sticky errors.
// Latency: standard mode data 1 cycle after get; FWFT head visible 1 cycle after put.
// Backpressure: put rejected while full unless get also accepted; sets overflow.
//
// Ports:
//   clk, reset (sync, active-low), clear (sync flush)
//   data_in/put write side, get/data_out read side
//   empty, full, almost_empty, almost_full, fillcount: occupancy status
//   overflow, underflow: sticky rejected-request flags
module fifo_sync_flags
  import fifo_sync_flags_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH_P2 = DEF_DEPTH_P2,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [WIDTH-1:0]            data_in,
  input  logic                        put,
  input  logic                        get,
  output logic [WIDTH-1:0]            data_out,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic [fill_w(DEPTH_P2)-1:0] fillcount,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int DEPTH = 2 ** DEPTH_P2;
  localparam int CW    = fill_w(DEPTH_P2);

  localparam logic [DEPTH_P2-1:0] PTR_ONE = DEPTH_P2'(1);
  localparam logic [CW-1:0]       CNT_ONE = CW'(1);
  localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]       AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0]       AE_C    = CW'(AE_LEVEL);

  if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
    $error("fifo_sync_flags: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [DEPTH_P2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_P2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  fifo_status_t        stat_q, stat_d;
  logic                wr_ok, rd_ok, ram_we;
  logic [WIDTH-1:0]    rd_dat;

  // Put while full is legal only when a get drains the head in the same cycle.
  assign wr_ok  = put & (~stat_q.full | get);
  assign rd_ok  = get & ~stat_q.empty;
  assign ram_we = wr_ok & ~clear & reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    stat_d   = stat_q;
    if (clear) begin
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      cnt_d           = '0;
      stat_d.overflow  = 1'b0;
      stat_d.underflow = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_ok && !rd_ok)      cnt_d = cnt_q + CNT_ONE;
      else if (rd_ok && !wr_ok) cnt_d = cnt_q - CNT_ONE;
      if (put && !wr_ok) stat_d.overflow  = 1'b1;
      if (get && !rd_ok) stat_d.underflow = 1'b1;
    end
    // Occupancy flags come from the next count so they never lag fillcount.
    stat_d.empty        = (cnt_d == '0);
    stat_d.full         = (cnt_d == DEPTH_C);
    stat_d.almost_empty = (cnt_d <= AE_C);
    stat_d.almost_full  = (cnt_d >= AF_C);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      stat_q   <= '{empty: 1'b1, full: 1'b0, almost_empty: 1'b1,
                    almost_full: 1'b0, overflow: 1'b0, underflow: 1'b0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      stat_q   <= stat_d;
    end
  end

  fifo_sync_ram #(
    .WIDTH (WIDTH),
    .AW    (DEPTH_P2)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (ram_we),
    .wr_addr_i (wr_ptr_q),
    .wr_dat_i  (data_in),
    .rd_addr_i (rd_ptr_q),
    .rd_dat_o  (rd_dat)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word shown directly; forced to zero while empty so stale storage never leaks.
    assign data_out = stat_q.empty ? '0 : rd_dat;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    // When full with put&get, the read samples the old head before the write lands.
    always_ff @(posedge clk) begin
      if (!reset) begin
        dout_q <= '0;
      end else if (!clear && rd_ok) begin
        dout_q <= rd_dat;
      end
    end
    assign data_out = dout_q;
  end

  assign empty        = stat_q.empty;
  assign full         = stat_q.full;
  assign almost_empty = stat_q.almost_empty;
  assign almost_full  = stat_q.almost_full;
  assign overflow     = stat_q.overflow;
  assign underflow    = stat_q.underflow;
  assign fillcount    = cnt_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Purpose: directed bench for fifo_sync_flags, standard and FWFT instances side by side.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises overflow, underflow, put+get at full and at empty.
module tb_fifo_sync_flags;

  localparam int W  = 8;
  localparam int P2 = 2;

  logic         clk = 1'b0;
  logic         reset, clear, put, get;
  logic [W-1:0] data_in;

  logic [W-1:0] dout0, dout1;
  logic         emp0, ful0, ae0, af0, ovf0, udf0;
  logic         emp1, ful1, ae1, af1, ovf1, udf1;
  logic [P2:0]  cnt0, cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(.WIDTH(W), .DEPTH_P2(P2), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .data_in(data_in), .put(put), .get(get),
    .data_out(dout0), .empty(emp0), .full(ful0), .almost_empty(ae0), .almost_full(af0),
    .fillcount(cnt0), .overflow(ovf0), .underflow(udf0)
  );

  fifo_sync_flags #(.WIDTH(W), .DEPTH_P2(P2), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .data_in(data_in), .put(put), .get(get),
    .data_out(dout1), .empty(emp1), .full(ful1), .almost_empty(ae1), .almost_full(af1),
    .fillcount(cnt1), .overflow(ovf1), .underflow(udf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic g, input logic [W-1:0] d);
    put     = p;
    get     = g;
    data_in = d;
  endtask

  initial begin
    logic [W-1:0] exp_q[$];

    reset = 1'b0; clear = 1'b0;
    drive(1'b1, 1'b0, 8'h99);

    // 1: reset dominates a concurrent put
    step(); step();
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    chk("rst_cnt",   32'(cnt0), 0);
    chk("rst_empty", 32'(emp0), 1);
    chk("rst_full",  32'(ful0), 0);
    chk("rst_ae",    32'(ae0),  1);
    chk("rst_af",    32'(af0),  0);
    chk("rst_ovf",   32'(ovf0), 0);
    chk("rst_udf",   32'(udf0), 0);
    chk("rst_dout0", 32'(dout0), 0);
    chk("rst_dout1", 32'(dout1), 0);

    // 2: fill to full, overflow, drain in order
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (exp_q[i]) begin
      drive(1'b1, 1'b0, exp_q[i]);
      step();
      chk("fill_cnt",  32'(cnt0), 32'(i + 1));
      chk("fill_af",   32'(af0),  (i + 1 >= 3) ? 1 : 0);
      chk("fill_ae",   32'(ae0),  (i + 1 <= 1) ? 1 : 0);
      chk("fill_full", 32'(ful0), (i + 1 == 4) ? 1 : 0);
    end
    drive(1'b1, 1'b0, 8'h55);
    step();
    chk("ovf_set",   32'(ovf0), 1);
    chk("ovf_cnt",   32'(cnt0), 4);
    foreach (exp_q[i]) begin
      drive(1'b0, 1'b1, 8'h00);
      step();
      chk("drain_dat", 32'(dout0), 32'(exp_q[i]));
      chk("drain_cnt", 32'(cnt0), 32'(3 - i));
    end
    chk("drain_empty", 32'(emp0), 1);
    chk("drain_udf",   32'(udf0), 0);

    // 3: put+get while full keeps the count, pointers wrap cleanly
    exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    foreach (exp_q[i]) begin
      drive(1'b1, 1'b0, exp_q[i]);
      step();
    end
    chk("pg_full_pre", 32'(ful0), 1);
    drive(1'b1, 1'b1, 8'hAA);
    step();
    chk("pg_cnt",  32'(cnt0), 4);
    chk("pg_full", 32'(ful0), 1);
    chk("pg_head", 32'(dout0), 32'hB1);
    chk("pg_ovf",  32'(ovf0), 1);
    exp_q = '{8'hB2, 8'hB3, 8'hB4, 8'hAA};
    foreach (exp_q[i]) begin
      drive(1'b0, 1'b1, 8'h00);
      step();
      chk("pg_drain", 32'(dout0), 32'(exp_q[i]));
    end
    chk("pg_empty", 32'(emp0), 1);

    // 4: put+get while empty accepts only the put
    drive(1'b1, 1'b1, 8'h5A);
    step();
    chk("ue_cnt",   32'(cnt0), 1);
    chk("ue_udf",   32'(udf0), 1);
    chk("ue_empty", 32'(emp0), 0);
    chk("ue_hold",  32'(dout0), 32'hAA);
    drive(1'b0, 1'b1, 8'h00);
    step();
    chk("ue_dat",   32'(dout0), 32'h5A);
    chk("ue_cnt0",  32'(cnt0), 0);

    // 5: FWFT head appears right after the put edge
    drive(1'b1, 1'b0, 8'h7E);
    step();
    chk("fw_dat",   32'(dout1), 32'h7E);
    chk("fw_empty", 32'(emp1), 0);
    chk("std_nodat", 32'(dout0), 32'h5A);
    drive(1'b0, 1'b1, 8'h00);
    step();
    chk("fw_pop_empty", 32'(emp1), 1);
    chk("fw_pop_cnt",   32'(cnt1), 0);
    chk("std_pop_dat",  32'(dout0), 32'h7E);

    // 6: clear with put overrides the write and clears sticky flags
    exp_q = '{8'hC1, 8'hC2, 8'hC3};
    foreach (exp_q[i]) begin
      drive(1'b1, 1'b0, exp_q[i]);
      step();
    end
    chk("cl_pre_cnt", 32'(cnt0), 3);
    chk("cl_pre_ovf", 32'(ovf0), 1);
    clear = 1'b1;
    drive(1'b1, 1'b0, 8'hEE);
    step();
    clear = 1'b0;
    chk("cl_cnt",   32'(cnt0), 0);
    chk("cl_empty", 32'(emp0), 1);
    chk("cl_ae",    32'(ae0),  1);
    chk("cl_ovf",   32'(ovf0), 0);
    chk("cl_udf",   32'(udf0), 0);
    chk("cl_hold",  32'(dout0), 32'h7E);
    chk("cl_fw_cnt", 32'(cnt1), 0);
    drive(1'b1, 1'b0, 8'hD1);
    step();
    chk("cl_fw_head", 32'(dout1), 32'hD1);
    drive(1'b1, 1'b0, 8'hD2);
    step();
    chk("cl_cnt2", 32'(cnt0), 2);
    drive(1'b0, 1'b1, 8'h00);
    step();
    chk("cl_rd1", 32'(dout0), 32'hD1);
    chk("cl_fw_next", 32'(dout1), 32'hD2);
    step();
    chk("cl_rd2", 32'(dout0), 32'hD2);
    chk("cl_end_empty", 32'(emp0), 1);
    drive(1'b0, 1'b0, 8'h00);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
